// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and state types for the 640x480@60 timing controller.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DFLT = 640;
  localparam int unsigned H_FP_DFLT     = 16;
  localparam int unsigned H_SYNC_DFLT   = 96;
  localparam int unsigned H_BP_DFLT     = 48;
  localparam int unsigned V_ACTIVE_DFLT = 480;
  localparam int unsigned V_FP_DFLT     = 10;
  localparam int unsigned V_SYNC_DFLT   = 2;
  localparam int unsigned V_BP_DFLT     = 33;
  localparam int unsigned PIX_DIV_DFLT  = 4;

  localparam int unsigned POS_W     = 10;
  localparam int unsigned MAX_TOTAL = 1024;

  typedef enum logic [1:0] {
    H_ACT  = 2'd0,
    H_FP   = 2'd1,
    H_SYNC = 2'd2,
    H_BP   = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_ACT  = 2'd0,
    V_FP   = 2'd1,
    V_SYNC = 2'd2,
    V_BP   = 2'd3
  } v_state_t;

  // Last position (inclusive) of a region that ends after n positions.
  function automatic logic [POS_W-1:0] pos_last(input int unsigned n);
    return POS_W'(n - 1);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_pix_tick_gen.sv
// Pixel-rate divider: emits a one-cycle strobe every PIX_DIV enabled clk_100 cycles.
module pix_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIX_DIV = PIX_DIV_DFLT
) (
  input  logic clk_100,
  input  logic rst,
  input  logic en,
  output logic pix_tick
);

  localparam int unsigned CNT_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by rst so no strobe escapes while reset is held.
  assign pix_tick = en & ~rst & (cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: horizontal/vertical FSMs, position counters and registered
// sync/blanking/start outputs, advanced by the pix_tick_gen pixel strobe.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE_DFLT,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP_DFLT,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC_DFLT,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP_DFLT,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE_DFLT,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP_DFLT,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC_DFLT,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP_DFLT,
  parameter int unsigned PIX_DIV  = vga_timing_pkg::PIX_DIV_DFLT
) (
  input  logic                              clk_100,
  input  logic                              rst,
  input  logic                              en,
  output logic                              pix_tick,
  output logic                              hsync,
  output logic                              vsync,
  output logic                              video_on,
  output logic [vga_timing_pkg::POS_W-1:0]  pix_x,
  output logic [vga_timing_pkg::POS_W-1:0]  pix_y,
  output logic                              line_start,
  output logic                              frame_start
);

  import vga_timing_pkg::*;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] H_ACT_END  = pos_last(H_ACTIVE);
  localparam logic [POS_W-1:0] H_FP_END   = pos_last(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] H_SYNC_END = pos_last(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] H_END      = pos_last(H_TOTAL);
  localparam logic [POS_W-1:0] V_ACT_END  = pos_last(V_ACTIVE);
  localparam logic [POS_W-1:0] V_FP_END   = pos_last(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] V_SYNC_END = pos_last(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [POS_W-1:0] V_END      = pos_last(V_TOTAL);

  // Reject timings the 10-bit position counters or the divider cannot represent.
  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_ctrl: H_TOTAL or V_TOTAL exceeds 1024");
  end
  if (PIX_DIV < 2) begin : g_bad_div
    $error("vga_timing_ctrl: PIX_DIV must be at least 2");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_region
    $error("vga_timing_ctrl: every timing region must be at least one unit long");
  end

  pix_tick_gen #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_tick_gen (
    .clk_100  (clk_100),
    .rst      (rst),
    .en       (en),
    .pix_tick (pix_tick)
  );

  h_state_t         h_state_q, h_state_d;
  v_state_t         v_state_q, v_state_d;
  logic [POS_W-1:0] pix_x_q, pix_x_d;
  logic [POS_W-1:0] pix_y_q, pix_y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             start_pend_q, start_pend_d;
  logic             line_wrap;

  // Position counters and FSM next state; everything moves only on pix_tick.
  always_comb begin
    line_wrap = pix_tick & (pix_x_q == H_END);

    pix_x_d = pix_x_q;
    if (pix_tick) begin
      pix_x_d = line_wrap ? '0 : pix_x_q + POS_W'(1);
    end

    pix_y_d = pix_y_q;
    if (line_wrap) begin
      pix_y_d = (pix_y_q == V_END) ? '0 : pix_y_q + POS_W'(1);
    end

    h_state_d = h_state_q;
    if (pix_tick) begin
      case (h_state_q)
        vga_timing_pkg::H_ACT:  if (pix_x_q == H_ACT_END)  h_state_d = vga_timing_pkg::H_FP;
        vga_timing_pkg::H_FP:   if (pix_x_q == H_FP_END)   h_state_d = vga_timing_pkg::H_SYNC;
        vga_timing_pkg::H_SYNC: if (pix_x_q == H_SYNC_END) h_state_d = vga_timing_pkg::H_BP;
        vga_timing_pkg::H_BP:   if (line_wrap)             h_state_d = vga_timing_pkg::H_ACT;
        default:                                           h_state_d = vga_timing_pkg::H_ACT;
      endcase
    end

    v_state_d = v_state_q;
    if (line_wrap) begin
      case (v_state_q)
        vga_timing_pkg::V_ACT:  if (pix_y_q == V_ACT_END)  v_state_d = vga_timing_pkg::V_FP;
        vga_timing_pkg::V_FP:   if (pix_y_q == V_FP_END)   v_state_d = vga_timing_pkg::V_SYNC;
        vga_timing_pkg::V_SYNC: if (pix_y_q == V_SYNC_END) v_state_d = vga_timing_pkg::V_BP;
        vga_timing_pkg::V_BP:   if (pix_y_q == V_END)      v_state_d = vga_timing_pkg::V_ACT;
        default:                                           v_state_d = vga_timing_pkg::V_ACT;
      endcase
    end
  end

  // Registered outputs decode the post-edge state so they align with pix_x/pix_y.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    start_pend_d  = start_pend_q & ~en;
    if (en) begin
      hsync_d       = (h_state_d != vga_timing_pkg::H_SYNC);
      vsync_d       = (v_state_d != vga_timing_pkg::V_SYNC);
      video_on_d    = (h_state_d == vga_timing_pkg::H_ACT) &&
                      (v_state_d == vga_timing_pkg::V_ACT);
      // First enabled cycle after reset announces position (0,0) once.
      line_start_d  = start_pend_q | (pix_tick & (pix_x_d == '0));
      frame_start_d = start_pend_q | (line_wrap & (pix_y_d == '0));
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      h_state_q     <= vga_timing_pkg::H_ACT;
      v_state_q     <= vga_timing_pkg::V_ACT;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      start_pend_q  <= 1'b1;
    end else begin
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      start_pend_q  <= start_pend_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl using a reduced timing so whole frames fit
// the run; a position-level reference model predicts every cycle's outputs.
module tb_vga_timing_ctrl;

  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int PD = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT * PD;

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       vid;
    logic       ls;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pix_tick, hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pix_x, pix_y;

  int n_checks = 0;
  int n_errors = 0;

  obs_t exp_q[$];

  vga_timing_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .PIX_DIV  (PD)
  ) dut (
    .clk_100     (clk),
    .rst         (rst),
    .en          (en),
    .pix_tick    (pix_tick),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: a divider count plus an (x,y) raster position; sync and
  // blanking are derived from the position ranges of each region.
  int m_cnt = 0, m_x = 0, m_y = 0;
  bit m_pend = 1'b1;
  bit m_hs = 1'b1, m_vs = 1'b1, m_vid = 1'b0;

  always @(posedge clk) begin
    obs_t e;
    bit   tick, ls, fs;
    ls = 1'b0;
    fs = 1'b0;
    if (rst) begin
      m_cnt = 0; m_x = 0; m_y = 0; m_pend = 1'b1;
      m_hs = 1'b1; m_vs = 1'b1; m_vid = 1'b0;
    end else if (en) begin
      tick  = (m_cnt == PD - 1);
      m_cnt = (m_cnt + 1) % PD;
      if (tick) begin
        m_x = m_x + 1;
        if (m_x == HT) begin
          m_x = 0;
          m_y = (m_y + 1) % VT;
        end
        ls = (m_x == 0);
        fs = (m_x == 0) && (m_y == 0);
      end
      if (m_pend) begin
        ls = 1'b1;
        fs = 1'b1;
        m_pend = 1'b0;
      end
      m_hs  = !(m_x >= HA + HF && m_x < HA + HF + HS);
      m_vs  = !(m_y >= VA + VF && m_y < VA + VF + VS);
      m_vid = (m_x < HA) && (m_y < VA);
    end
    e.tick = en && !rst && (m_cnt == PD - 1);
    e.hs   = m_hs;
    e.vs   = m_vs;
    e.vid  = m_vid;
    e.ls   = ls;
    e.fs   = fs;
    e.x    = 10'(m_x);
    e.y    = 10'(m_y);
    exp_q.push_back(e);
  end

  // Monitor: outputs are presented every cycle; compare just after the edge.
  always @(posedge clk) begin
    obs_t got, e;
    #1;
    got = '{tick: pix_tick, hs: hsync, vs: vsync, vid: video_on, ls: line_start,
            fs: frame_start, x: pix_x, y: pix_y};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty t=%0t got x=%0d y=%0d", $time, pix_x, pix_y);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_errors++;
        $display("FAIL outputs t=%0t got tick=%b hs=%b vs=%b vid=%b ls=%b fs=%b x=%0d y=%0d | exp tick=%b hs=%b vs=%b vid=%b ls=%b fs=%b x=%0d y=%0d",
                 $time, got.tick, got.hs, got.vs, got.vid, got.ls, got.fs, got.x, got.y,
                 e.tick, e.hs, e.vs, e.vid, e.ls, e.fs, e.x, e.y);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Returns at a negedge where sel's pulse is high, or times out.
  task automatic wait_pulse(input bit use_frame, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      if (use_frame ? frame_start : line_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(use_frame ? "frame_start_timeout" : "line_start_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      if (int'(pix_x) == x && (y < 0 || int'(pix_y) == y)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("position_timeout", 0, 1);
  endtask

  int watchdog = 0;
  always @(posedge clk) begin
    watchdog++;
    if (watchdog > 90000) begin
      $display("FAIL watchdog cycles=%0d limit=90000", watchdog);
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    bit ok;
    int cyc, vs_lo, hs_lo, vid_hi, ls_cnt, en_pct;

    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Frame-level periods measured between two consecutive frame_start pulses.
    wait_pulse(1'b1, ok);
    if (ok) begin
      cyc = 0; vs_lo = 0; hs_lo = 0; vid_hi = 0; ls_cnt = 0;
      do begin
        if (!vsync) vs_lo++;
        if (!hsync) hs_lo++;
        if (video_on) vid_hi++;
        if (line_start) ls_cnt++;
        @(negedge clk);
        cyc++;
      end while (!frame_start && cyc < 2 * FRAME);
      chk("frame_period", cyc, FRAME);
      chk("vsync_low_cycles", vs_lo, VS * HT * PD);
      chk("hsync_low_cycles_per_frame", hs_lo, HS * PD * VT);
      chk("video_on_cycles_per_frame", vid_hi, HA * VA * PD);
      chk("line_starts_per_frame", ls_cnt, VT);
    end

    wait_pulse(1'b0, ok);
    if (ok) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!line_start && cyc < 2 * FRAME);
      chk("line_period", cyc, HT * PD);
    end

    // Freeze on the last visible pixel of a line.
    wait_pos(HA - 1, -1, ok);
    en = 1'b0;
    repeat (100) @(negedge clk);
    en = 1'b1;
    wait_pos(HA, -1, ok);
    chk("resume_video_off", int'(video_on), 0);

    // Reset landing inside horizontal sync mid-frame.
    wait_pos(HA + HF + 2, VA / 2, ok);
    chk("pre_reset_hsync_low", int'(hsync), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_hsync", int'(hsync), 1);
    chk("reset_pix_x", int'(pix_x), 0);
    chk("reset_pix_y", int'(pix_y), 0);
    chk("reset_video_on", int'(video_on), 0);
    rst = 1'b0;

    // Randomised enable duty and occasional resets.
    en_pct = 100;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (i % 500 == 0) begin
        case ($urandom_range(0, 2))
          0:       en_pct = 100;
          1:       en_pct = 90;
          default: en_pct = 50;
        endcase
      end
      en  = ($urandom_range(0, 99) < en_pct);
      rst = ($urandom_range(0, 1999) == 0);
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  H_ACTIVE, 640, visible pixels per line
  H_FP, 16, horizontal front porch (pixels)
  H_SYNC, 96, hsync width (pixels)
  H_BP, 48, horizontal back porch (pixels)
  V_ACTIVE, 480, visible lines per frame
  V_FP, 10, vertical front porch (lines)
  V_SYNC, 2, vsync width (lines)
  V_BP, 33, vertical back porch (lines)
  PIX_DIV, 4, clk_100 cycles per pixel (25 MHz pixel rate)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk_100  in  1  100 MHz clock; the only clock; all logic on its rising edge
  rst  in  1  synchronous, active-high reset
  en  in  1  run enable; low freezes timing
  pix_tick  out  1  one-cycle pixel strobe
  hsync  out  1  horizontal sync, active low
  vsync  out  1  vertical sync, active low
  video_on  out  1  high inside the visible region
  pix_x  out  10  horizontal position, 0..H_TOTAL-1
  pix_y  out  10  vertical position, 0..V_TOTAL-1
  line_start  out  1  one-cycle pulse when pix_x becomes 0
  frame_start  out  1  one-cycle pulse when pix_x and pix_y both become 0

Function
REQ-003 H_TOTAL and V_TOTAL SHALL be the sums of their four parameters (800 and 525 by default); elaboration SHALL fail if either total exceeds 1024 or PIX_DIV < 2.
REQ-004 Divider SHALL count 0..PIX_DIV-1 while en=1; pix_tick=1 exactly in cycles where count==PIX_DIV-1 and en=1.
REQ-005 Horizontal FSM SHALL have states H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT; each transition occurs on the pix_tick that ends the state's last pixel.
REQ-006 Vertical FSM SHALL have states V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT; it advances only on the pix_tick where pix_x wraps H_TOTAL-1 -> 0.
REQ-007 pix_x SHALL increment on each pix_tick and wrap H_TOTAL-1 -> 0; pix_y SHALL increment on each pix_x wrap and wrap V_TOTAL-1 -> 0 in the same cycle.
REQ-008 hsync SHALL be 0 iff in H_SYNC; vsync SHALL be 0 iff in V_SYNC; video_on SHALL be 1 iff in H_ACT and V_ACT.
REQ-009 Defaults: hsync low for pix_x 656..751; vsync low for pix_y 490..491.
REQ-010 All outputs except pix_tick SHALL be driven from flops, mutually aligned, and update on the clock edge that ends the pix_tick cycle (latency 1 clk from tick).
REQ-011 line_start and frame_start SHALL be high for exactly one clk_100 cycle, in the first cycle showing the new position.
REQ-012 With en=0, divider, counters and FSMs SHALL hold; hsync, vsync, video_on, pix_x and pix_y SHALL hold; pix_tick, line_start and frame_start SHALL be 0; on en rising, operation resumes from the held divider count.
REQ-013 Defaults: line period SHALL be 3200 clk_100 cycles and frame period 1,680,000 cycles.

Reset
REQ-014 While rst=1, regardless of en: divider=0, H_ACT, V_ACT, pix_x=0, pix_y=0, hsync=1, vsync=1, video_on=0, pix_tick=0, line_start=0, frame_start=0.
REQ-015 In the first cycle after rst falls, outputs SHALL reflect position (0,0): video_on=1, line_start=1, frame_start=1 (one cycle).
REQ-016 rst asserted mid-line or mid-sync SHALL take effect at the next clock edge with no partial pulse completion.

Structure
REQ-017 Package vga_timing_pkg SHALL hold the default timing constants and enumerated types h_state_t and v_state_t.
REQ-018 The divider SHALL be the sub-module pix_tick_gen (inputs clk_100, rst, en; output pix_tick); the FSMs and counters remain in vga_timing_ctrl.

Verification
REQ-019 rst high 3 cycles, then release with en=1 -> next cycle pix_x=0, pix_y=0, video_on=1, hsync=vsync=1, line_start=frame_start=1; pix_tick every 4th cycle.
REQ-020 Run one line -> video_on high 640 ticks; hsync low 384 clk starting when pix_x=656; line_start period 3200 clk.
REQ-021 Run full frame -> vsync low exactly 6400 clk starting when pix_y=490; frame_start period 1,680,000 clk.
REQ-022 en=0 at pix_x=639 for 100 cycles -> all outputs frozen, no pulses; after en=1, next tick gives pix_x=640, video_on=0.
REQ-023 rst pulse at pix_x=700, pix_y=300 (in hsync) -> next edge hsync=1, pix_x=0, pix_y=0, video_on=0.
REQ-024 Tick at pix_x=799, pix_y=524 -> pix_x=0, pix_y=0, FSMs H_ACT/V_ACT, line_start and frame_start high 1 cycle.
